tone_seq: RTL and testbench



---
 rtl/tone_seq_pkg.sv | 59 +++++
 rtl/tone_seq_tone_gen.sv | 33 +++
 rtl/tone_seq.sv | 140 ++++++++++++++
 tb/tb_tone_seq.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tone_seq_pkg.sv
// Shared types and tone tables for the tone_seq score player.
// Notes are semitones from C4 (code 1) upward; code 0 is a rest.
package tone_seq_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StLoad,
        StPlay,
        StGap
    } state_t;

    localparam int unsigned NOTE_TAB_CNT = 31;

    // Semitone frequency table in Hz, C4 upward; anything outside the table is silent.
    function automatic int unsigned freq_hz(int unsigned note);
        case (note)
            1:       freq_hz = 261;
            2:       freq_hz = 277;
            3:       freq_hz = 294;
            4:       freq_hz = 311;
            5:       freq_hz = 330;
            6:       freq_hz = 349;
            7:       freq_hz = 370;
            8:       freq_hz = 392;
            9:       freq_hz = 415;
            10:      freq_hz = 440;
            11:      freq_hz = 466;
            12:      freq_hz = 494;
            13:      freq_hz = 523;
            14:      freq_hz = 554;
            15:      freq_hz = 587;
            16:      freq_hz = 622;
            17:      freq_hz = 659;
            18:      freq_hz = 698;
            19:      freq_hz = 740;
            20:      freq_hz = 784;
            21:      freq_hz = 831;
            22:      freq_hz = 880;
            23:      freq_hz = 932;
            24:      freq_hz = 988;
            25:      freq_hz = 1047;
            26:      freq_hz = 1109;
            27:      freq_hz = 1175;
            28:      freq_hz = 1245;
            29:      freq_hz = 1319;
            30:      freq_hz = 1397;
            31:      freq_hz = 1480;
            default: freq_hz = 0;
        endcase
    endfunction

    function automatic int unsigned half_period(int unsigned clk_hz, int unsigned note);
        int unsigned f;
        f = freq_hz(note);
        half_period = (f == 0) ? 0 : clk_hz / (2 * f);
    endfunction

endpackage

// File: rtl/tone_seq_tone_gen.sv
// Square-wave generator: counts enabled cycles and toggles bell every half_period.
// clear returns the phase and the output to 0.
module tone_gen #(
    parameter int unsigned W = 18
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clear,
    input  logic [W-1:0] half_period,
    output logic         bell
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            bell  <= 1'b0;
        end else if (clear) begin
            cnt_q <= '0;
            bell  <= 1'b0;
        end else if (en) begin
            if (cnt_q == half_period - 1'b1) begin
                cnt_q <= '0;
                bell  <= ~bell;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/tone_seq.sv
// Score-playing tone sequencer: fetches {note, dur} words and plays them on bell.
// Define TONE_SEQ_LOOP_EN to restart the score at address 0 instead of ending.
module tone_seq
    import tone_seq_pkg::*;
#(
    parameter int unsigned CLK_HZ   = 100_000_000,
    parameter int unsigned NOTE_W   = 5,
    parameter int unsigned DUR_W    = 4,
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned BEAT_DIV = 12_500_000,
    parameter int unsigned GAP_CYC  = 1_250_000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    stop,
    input  logic                    pause,
    output logic [ADDR_W-1:0]       score_addr,
    input  logic [NOTE_W+DUR_W-1:0] score_data,
    output logic                    bell,
    output logic [NOTE_W-1:0]       note_cur,
    output logic                    busy,
    output logic                    done
);

    localparam int unsigned NOTE_NUM = 2 ** NOTE_W;
    localparam int unsigned BEAT_MAX = (2 ** DUR_W - 1) * BEAT_DIV;
    localparam int unsigned BEAT_W   = $clog2(BEAT_MAX + 1);
    localparam int unsigned TONE_MAX = half_period(CLK_HZ, 1);
    localparam int unsigned TONE_W   = $clog2(TONE_MAX + 1);

    state_t              state_q;
    logic [BEAT_W-1:0]   beat_cnt_q;
    logic [NOTE_W-1:0]   note_in;
    logic [DUR_W-1:0]    dur_in;
    logic [BEAT_W-1:0]   play_len;
    logic                last_addr;
    logic                beat_last;
    logic                score_end;
    logic [TONE_W-1:0]   hp_rom [NOTE_NUM];
    logic [TONE_W-1:0]   hp_cur;
    logic                tone_en;

    assign {note_in, dur_in} = score_data;
    assign play_len  = BEAT_W'(dur_in) * BEAT_W'(BEAT_DIV) - BEAT_W'(GAP_CYC);
    assign last_addr = &score_addr;
    assign beat_last = (beat_cnt_q == BEAT_W'(1));

    // Half-periods are elaboration-time constants, so this is a ROM, not a divider.
    for (genvar i = 0; i < NOTE_NUM; i++) begin : g_hp
        assign hp_rom[i] = TONE_W'(half_period(CLK_HZ, i));
    end
    assign hp_cur = hp_rom[note_cur];

    assign score_end = ((state_q == StLoad) && (dur_in == '0)) ||
                       ((state_q == StGap) && !pause && beat_last && last_addr);

    // Dropping enable on the last PLAY cycle guarantees bell is already low in GAP.
    assign tone_en = (state_q == StPlay) && !pause && !stop && !beat_last && (hp_cur != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            beat_cnt_q <= '0;
            score_addr <= '0;
            note_cur   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (stop) begin
                state_q    <= StIdle;
                beat_cnt_q <= '0;
                score_addr <= '0;
                note_cur   <= '0;
                busy       <= 1'b0;
            end else if (score_end) begin
`ifdef TONE_SEQ_LOOP_EN
                state_q <= StFetch;
`else
                state_q <= StIdle;
                busy    <= 1'b0;
                done    <= 1'b1;
`endif
                score_addr <= '0;
                note_cur   <= '0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (start) begin
                            state_q    <= StFetch;
                            score_addr <= '0;
                            busy       <= 1'b1;
                        end
                    end
                    StFetch: state_q <= StLoad;
                    StLoad: begin
                        note_cur   <= note_in;
                        beat_cnt_q <= play_len;
                        state_q    <= StPlay;
                    end
                    StPlay: begin
                        if (!pause) begin
                            if (beat_last) begin
                                state_q    <= StGap;
                                note_cur   <= '0;
                                beat_cnt_q <= BEAT_W'(GAP_CYC);
                            end else begin
                                beat_cnt_q <= beat_cnt_q - 1'b1;
                            end
                        end
                    end
                    StGap: begin
                        if (!pause) begin
                            if (beat_last) begin
                                state_q    <= StFetch;
                                score_addr <= score_addr + 1'b1;
                            end else begin
                                beat_cnt_q <= beat_cnt_q - 1'b1;
                            end
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    tone_gen #(
        .W (TONE_W)
    ) u_tone_gen (
        .clk         (clk),
        .rst         (rst),
        .en          (tone_en),
        .clear       (!tone_en),
        .half_period (hp_cur),
        .bell        (bell)
    );

endmodule

// File: tb/tb_tone_seq.sv
// Self-checking bench for tone_seq with scaled-down timing (2 MHz clock, 1000-clock beats).
module tb_tone_seq;

    localparam int PER  = 10;
    localparam int BD   = 1000;
    localparam int GAP  = 100;
    localparam int WBD  = 8;
    localparam int WGAP = 2;

    typedef struct {
        int note;
        int dur;
        int hp;
    } entry_t;

    logic       clk = 1'b0;
    logic       rst, start, stop, pause;
    logic [7:0] score_addr;
    logic [8:0] score_data;
    logic       bell, busy, done;
    logic [4:0] note_cur;
    logic [8:0] mem [256];

    logic       w_start, w_stop, w_pause;
    logic [7:0] w_addr;
    logic [8:0] w_data;
    logic       w_bell, w_busy, w_done;
    logic [4:0] w_note;

    int     errors = 0;
    int     checks = 0;
    entry_t tab [5];
    entry_t sb [$];

    always #5 clk = ~clk;
    always @(posedge clk) score_data <= mem[score_addr];
    assign w_data = {5'd1, 4'd1};

    tone_seq #(
        .CLK_HZ(2_000_000), .NOTE_W(5), .DUR_W(4), .ADDR_W(8), .BEAT_DIV(BD), .GAP_CYC(GAP)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause),
        .score_addr(score_addr), .score_data(score_data), .bell(bell),
        .note_cur(note_cur), .busy(busy), .done(done)
    );

    tone_seq #(
        .CLK_HZ(2_000_000), .NOTE_W(5), .DUR_W(4), .ADDR_W(8), .BEAT_DIV(WBD), .GAP_CYC(WGAP)
    ) dut_w (
        .clk(clk), .rst(rst), .start(w_start), .stop(w_stop), .pause(w_pause),
        .score_addr(w_addr), .score_data(w_data), .bell(w_bell),
        .note_cur(w_note), .busy(w_busy), .done(w_done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic pulse_start(output time t0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t0 = $time;
        check("start_busy", busy, 1);
    endtask

    task automatic wait_note(input logic [4:0] n, input string tag);
        int w = 0;
        while (note_cur !== n && w < 10) begin
            @(negedge clk);
            w++;
        end
        check({tag, "_note_latency"}, w, 2);
    endtask

    // Pops expected entries and walks each one cycle by cycle from its FETCH cycle.
    task automatic play_entries(input string tag);
        int k = 0;
        while (sb.size() > 0) begin
            entry_t e;
            int mn, mb, mc, len;
            e = sb.pop_front();
            len = e.dur * BD - GAP;
            mn = 0;
            mb = 0;
            mc = 0;
            check($sformatf("%s_e%0d_addr", tag, k), score_addr, k);
            for (int c = 0; c < e.dur * BD + 2; c++) begin
                bit on;
                int nexp, bexp;
                on = (c >= 2) && (c < 2 + len);
                nexp = on ? e.note : 0;
                bexp = (on && e.note != 0) ? ((c - 2) / e.hp) % 2 : 0;
                if (note_cur !== 5'(nexp)) mn++;
                if (bell !== bexp[0]) mb++;
                if (busy !== 1'b1 || done !== 1'b0 || score_addr !== 8'(k)) mc++;
                @(negedge clk);
            end
            check($sformatf("%s_e%0d_note", tag, k), mn, 0);
            check($sformatf("%s_e%0d_bell", tag, k), mb, 0);
            check($sformatf("%s_e%0d_ctl", tag, k), mc, 0);
            k++;
        end
    endtask

    task automatic finish_score(input time t0, input int exp_cyc, input logic [4:0] first,
                                input string tag);
`ifdef TONE_SEQ_LOOP_EN
        int w = 0;
        while ($time < t0 + exp_cyc * PER && w < exp_cyc + 10) begin
            @(negedge clk);
            w++;
        end
        check({tag, "_loop_done"}, done, 0);
        check({tag, "_loop_busy"}, busy, 1);
        check({tag, "_loop_addr"}, score_addr, 0);
        tick(2);
        check({tag, "_loop_replay"}, note_cur, first);
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        check({tag, "_loop_stop_busy"}, busy, 0);
`else
        while (done !== 1'b1 && $time < t0 + (exp_cyc + 20) * PER) @(negedge clk);
        check({tag, "_done_cycle"}, int'(($time - t0) / PER), exp_cyc);
        check({tag, "_end_busy"}, busy, 0);
        check({tag, "_end_addr"}, score_addr, 0);
        tick(1);
        check({tag, "_done_pulse"}, done, 0);
        if (first == 5'd0) check({tag, "_end_note"}, note_cur, 0);
`endif
    endtask

    task automatic run_score(input int n, input string tag);
        time t0;
        int  total = 2;
        for (int i = 0; i < n; i++) begin
            mem[i] = {5'(tab[i].note), 4'(tab[i].dur)};
            sb.push_back(tab[i]);
            total += tab[i].dur * BD + 2;
        end
        mem[n] = '0;
        pulse_start(t0);
        play_entries(tag);
        finish_score(t0, total, 5'(tab[0].note), tag);
        tick(2);
    endtask

    task automatic load_short_score();
        mem[0] = {5'd31, 4'd2};
        mem[1] = {5'd0, 4'd1};
        mem[2] = '0;
    endtask

    initial begin
        #(3_000_000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        time        t0;
        int         m;
        logic [7:0] last;
        rst = 1'b1;
        start = 1'b0;
        stop = 1'b0;
        pause = 1'b0;
        w_start = 1'b0;
        w_stop = 1'b0;
        w_pause = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        // {note, dur, floor(2e6 / (2 * f))}
        tab[0] = '{10, 2, 2272};
        tab[1] = '{0, 1, 0};
        tab[2] = '{31, 2, 675};
        tab[3] = '{25, 1, 955};
        tab[4] = '{1, 3, 3831};

        tick(3);
        check("reset_bell", bell, 0);
        check("reset_note", note_cur, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_addr", score_addr, 0);
        rst = 1'b0;
        tick(2);

        run_score(2, "basic");
        run_score(5, "mix");

        // Pause for 500 clocks while the tone is high.
        load_short_score();
        pulse_start(t0);
        wait_note(5'd31, "pause");
        tick(700);
        check("pause_bell_pre", bell, 1);
        pause = 1'b1;
        m = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (bell !== 1'b0 || note_cur !== 5'd31 || busy !== 1'b1) m++;
        end
        pause = 1'b0;
        check("pause_hold", m, 0);
        tick(674);
        check("pause_phase_low", bell, 0);
        tick(1);
        check("pause_phase_high", bell, 1);
        finish_score(t0, 3006 + 500, 5'd31, "pause");
        tick(2);

        // Stop mid-note, then stop+start together while idle.
        load_short_score();
        pulse_start(t0);
        wait_note(5'd31, "stop");
        tick(700);
        check("stop_bell_pre", bell, 1);
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        check("stop_busy", busy, 0);
        check("stop_bell", bell, 0);
        check("stop_addr", score_addr, 0);
        check("stop_note", note_cur, 0);
        m = 0;
        for (int i = 0; i < 3200; i++) begin
            if (done !== 1'b0 || busy !== 1'b0) m++;
            @(negedge clk);
        end
        check("stop_no_done", m, 0);
        stop = 1'b1;
        start = 1'b1;
        tick(1);
        stop = 1'b0;
        start = 1'b0;
        check("stop_over_start", busy, 0);
        tick(2);

        // Asynchronous reset mid-note.
        load_short_score();
        pulse_start(t0);
        wait_note(5'd31, "rst");
        tick(700);
        check("rst_bell_pre", bell, 1);
        rst = 1'b1;
        #1;
        check("rst_bell", bell, 0);
        check("rst_busy", busy, 0);
        check("rst_note", note_cur, 0);
        check("rst_addr", score_addr, 0);
        check("rst_done", done, 0);
        @(negedge clk);
        tick(1);
        rst = 1'b0;
        m = 0;
        for (int i = 0; i < 50; i++) begin
            if (bell !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || note_cur !== 5'd0 ||
                score_addr !== 8'd0) m++;
            @(negedge clk);
        end
        check("rst_hold", m, 0);

        // Full 256-entry score with no terminator on the short-beat instance.
        w_start = 1'b1;
        tick(1);
        w_start = 1'b0;
        check("wrap_start_busy", w_busy, 1);
        m = 0;
        last = '0;
        for (int k = 0; k < 256; k++) begin
            for (int c = 0; c < WBD + 2; c++) begin
                if (c == 0 && w_addr !== 8'(k)) m++;
                if (c == 0 && k == 255) last = w_addr;
                if (w_done !== 1'b0 || w_busy !== 1'b1) m++;
                @(negedge clk);
            end
        end
        check("wrap_walk", m, 0);
        check("wrap_last_addr", last, 255);
`ifdef TONE_SEQ_LOOP_EN
        check("wrap_loop_done", w_done, 0);
        check("wrap_loop_busy", w_busy, 1);
        check("wrap_loop_addr", w_addr, 0);
        w_stop = 1'b1;
        tick(1);
        w_stop = 1'b0;
        check("wrap_loop_stop", w_busy, 0);
`else
        check("wrap_done", w_done, 1);
        check("wrap_addr", w_addr, 0);
        check("wrap_busy", w_busy, 0);
        tick(1);
        check("wrap_done_pulse", w_done, 0);
`endif
        tick(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
